mem_elec_seq: RTL and testbench

Parametrised electrovalve pattern sequencer for the fire-fighting machine controller. It holds a small writable table of actuator patterns, each with its own dwell time. On command it plays the table out on `salida`: one-shot or looped, abortable at any time. When not playing it drives a fixed safe pattern. It sits between the control FSM and the valve/actuator output drivers.

---
 rtl/mem_elec_seq.sv | 122 ++++++++++++
 tb/tb_mem_elec_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_elec_seq.sv
// Electrovalve pattern sequencer: a writable table of (pattern, dwell) entries
// played out on salida one-shot or looped; drives SAFE_PATTERN whenever idle.
module mem_elec_seq #(
    parameter int                WIDTH        = 11,
    parameter int                DEPTH        = 8,
    parameter int                AW           = 3,
    parameter int                DWELL_W      = 8,
    parameter logic [WIDTH-1:0]  SAFE_PATTERN = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [AW-1:0]      last_idx,
    output logic [WIDTH-1:0]   salida,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      cur_idx
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     salida_q, salida_d;
    logic                 done_q, done_d;
    logic [AW-1:0]        last_q, last_d;
    logic                 loop_q, loop_d;

    logic [WIDTH-1:0]     pat_q [DEPTH];
    logic [DWELL_W-1:0]   dwl_q [DEPTH];

    // Table writes land at the edge, so a fetch in the same cycle sees old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pat_q[i] <= SAFE_PATTERN;
                dwl_q[i] <= '0;
            end
        end else if (wr_en) begin
            pat_q[wr_addr] <= wr_data;
            dwl_q[wr_addr] <= wr_dwell;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        salida_d = salida_q;
        done_d   = 1'b0;
        last_d   = last_q;
        loop_d   = loop_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = RUN;
                    idx_d    = '0;
                    salida_d = pat_q[0];
                    cnt_d    = dwl_q[0];
                    last_d   = last_idx;
                    loop_d   = loop;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    salida_d = SAFE_PATTERN;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (idx_q != last_q) begin
                    idx_d    = idx_q + AW'(1);
                    salida_d = pat_q[idx_q + AW'(1)];
                    cnt_d    = dwl_q[idx_q + AW'(1)];
                end else if (loop_q) begin
                    idx_d    = '0;
                    salida_d = pat_q[0];
                    cnt_d    = dwl_q[0];
                end else begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    salida_d = SAFE_PATTERN;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            salida_q <= SAFE_PATTERN;
            done_q   <= 1'b0;
            last_q   <= '0;
            loop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            salida_q <= salida_d;
            done_q   <= done_d;
            last_q   <= last_d;
            loop_q   <= loop_d;
        end
    end

    assign salida  = salida_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign cur_idx = idx_q;

endmodule

// File: tb/tb_mem_elec_seq.sv
// Directed bench for mem_elec_seq: inputs driven and outputs sampled 1 time
// unit after each rising edge; expectations are hand-derived tables.
module tb_mem_elec_seq;

    logic        clk = 1'b0;
    logic        reset, wr_en, start, stop, loop;
    logic [2:0]  wr_addr, last_idx, cur_idx;
    logic [10:0] wr_data, salida;
    logic [7:0]  wr_dwell;
    logic        busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    mem_elec_seq dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dwell(wr_dwell), .start(start), .stop(stop),
        .loop(loop), .last_idx(last_idx), .salida(salida), .busy(busy),
        .done(done), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [10:0] d, input logic [7:0] dw);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dwell = dw;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            n_cmp++;
            if (salida !== 11'h7FF || busy !== 1'b0 || done !== 1'b0 || cur_idx !== 3'd0) begin
                n_bad++;
                $display("FAIL reset_idle c=%0d: got salida=%h busy=%b done=%b idx=%0d, want 7ff 0 0 0",
                         c, salida, busy, done, cur_idx);
            end
            tick();
        end
    endtask

    task automatic test_oneshot();
        logic [10:0] es [6] = '{11'h586, 11'h586, 11'h586, 11'h001, 11'h7FF, 11'h7FF};
        logic        ed [6] = '{0, 0, 0, 0, 1, 0};
        logic        eb [6] = '{1, 1, 1, 1, 0, 0};
        logic [2:0]  ei [6] = '{0, 0, 0, 1, 0, 0};
        wr(3'd0, 11'h586, 8'd2);
        wr(3'd1, 11'h001, 8'd0);
        last_idx = 3'd1; loop = 1'b0; start = 1'b1;
        tick();
        // start held and last_idx/loop changed mid-run must have no effect
        last_idx = 3'd0; loop = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) start = 1'b0;
            n_cmp++;
            if (salida !== es[c] || done !== ed[c] || busy !== eb[c] || cur_idx !== ei[c]) begin
                n_bad++;
                $display("FAIL oneshot c=%0d: got %h d=%b b=%b i=%0d, want %h d=%b b=%b i=%0d",
                         c, salida, done, busy, cur_idx, es[c], ed[c], eb[c], ei[c]);
            end
            tick();
        end
    endtask

    task automatic test_loop();
        logic [10:0] es [4] = '{11'h586, 11'h586, 11'h586, 11'h001};
        last_idx = 3'd1; loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            n_cmp++;
            if (salida !== es[c % 4] || done !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL loop c=%0d: got %h d=%b b=%b, want %h d=0 b=1",
                         c, salida, done, busy, es[c % 4]);
            end
            tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;
        n_cmp++;
        if (salida !== 11'h7FF || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL loop_stop: got %h b=%b d=%b, want 7ff b=0 d=0", salida, busy, done);
        end
        tick();
    endtask

    task automatic test_stop();
        last_idx = 3'd1; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (salida !== 11'h586 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_pre: got %h b=%b, want 586 b=1", salida, busy);
        end
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (salida !== 11'h7FF || busy !== 1'b0 || done !== 1'b0 || cur_idx !== 3'd0) begin
                n_bad++;
                $display("FAIL stop c=%0d: got %h b=%b d=%b i=%0d, want 7ff 0 0 0",
                         c, salida, busy, done, cur_idx);
            end
            tick();
        end
    endtask

    task automatic test_write_during_play();
        logic [10:0] es [5] = '{11'h586, 11'h586, 11'h586, 11'h0F0, 11'h7FF};
        logic        ed [5] = '{0, 0, 0, 0, 1};
        logic [10:0] es2 [5] = '{11'h586, 11'h586, 11'h586, 11'h123, 11'h7FF};
        last_idx = 3'd1; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (salida !== es[c] || done !== ed[c]) begin
                n_bad++;
                $display("FAIL wr_play c=%0d: got %h d=%b, want %h d=%b", c, salida, done, es[c], ed[c]);
            end
            wr_en = (c == 0 || c == 2);
            wr_addr = 3'd1;
            wr_data = (c == 0) ? 11'h0F0 : 11'h123;
            wr_dwell = 8'd0;
            // back-to-back restart accepted in the done cycle
            start = (c == 4);
            tick();
            wr_en = 1'b0;
        end
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (salida !== es2[c] || done !== ed[c]) begin
                n_bad++;
                $display("FAIL b2b c=%0d: got %h d=%b, want %h d=%b", c, salida, done, es2[c], ed[c]);
            end
            tick();
        end
    endtask

    task automatic test_reset_run();
        last_idx = 3'd1; loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++;
        if (salida !== 11'h7FF || busy !== 1'b0 || done !== 1'b0 || cur_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL rst_run: got %h b=%b d=%b i=%0d, want 7ff 0 0 0", salida, busy, done, cur_idx);
        end
        last_idx = 3'd0; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (salida !== 11'h7FF || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_replay0: got %h b=%b d=%b, want 7ff b=1 d=0", salida, busy, done);
        end
        tick();
        n_cmp++;
        if (salida !== 11'h7FF || busy !== 1'b0 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_replay1: got %h b=%b d=%b, want 7ff b=0 d=1", salida, busy, done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_replay2: got d=%b, want d=0", done);
        end
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        wr_addr = '0; wr_data = '0; wr_dwell = '0; last_idx = '0;
        #2;
        test_reset();
        test_oneshot();
        test_loop();
        test_stop();
        test_write_during_play();
        test_reset_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
